usb_fs_rx_deserializer: RTL and testbench
=========================================

Name: usb_fs_rx_deserializer

Overview:
- Full-speed (12 Mb/s) USB receive front-end in the poc_usbdev datapath, directly downstream of the D+/D- pad inputs.
- Oversamples the raw line, recovers bit timing, and detects SYNC.
- NRZI-decodes and removes stuffed bits, then assembles bytes LSB-first.
- Delivers bytes, EOP and error strobes to the packet/PID decoder that consumes them.

Parameters:
- OVERSAMPLE, 4: clk cycles per nominal bit; clk = 48 MHz. Legal values are even and ≥4.
- SYNC_STAGES, 2: metastability flops on dp/dm. Minimum 2.
- SYNC_TIMEOUT, 16: bit times allowed in SYNC before returning to IDLE.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; 0 forces IDLE
- dp_in  in  1  raw D+ from pad
- dm_in  in  1  raw D- from pad
- line_state  out  2  synchronized line: 00=SE0, 01=J, 10=K, 11=SE1
- rx_active  out  1  high from SYNC match until EOP/abort completes
- rx_data  out  8  last assembled byte; holds until next byte
- rx_valid  out  1  one-cycle strobe, rx_data new
- rx_eop  out  1  one-cycle strobe, packet ended cleanly or with residue error
- rx_err  out  1  one-cycle strobe on stuff violation, SE1, or bad residue

Behaviour:
- Reset, asynchronous:
  - Synchronizer flops reset to J, so line_state=01.
  - rx_data=0x00; rx_active, rx_valid, rx_eop, rx_err = 0.
  - State = IDLE; all counters = 0.
- ena=0: synchronous return to IDLE. Strobes and rx_active = 0, rx_data held. line_state keeps tracking the line.
- Clock recovery:
  - Phase counter runs mod OVERSAMPLE and clears on any synchronized J/K transition.
  - bit_strobe fires when the counter equals OVERSAMPLE/2-1.
  - All decoding happens on bit_strobe only.
- NRZI decoding: decoded bit = 1 if the sampled level equals the previous sample, 0 if it changed. The previous level resets to J.
- FSM states: IDLE, SYNC, DATA, EOP, ABORT.
  - IDLE: first K at bit_strobe → SYNC.
  - SYNC:
    - Track alternation.
    - Two consecutive K samples after ≥3 alternations (the end of KJKJKJKK) → DATA, and rx_active=1 from the next cycle.
    - SE0 → IDLE.
    - SYNC_TIMEOUT bit times without a match → IDLE.
  - DATA:
    - Ones counter increments on decoded 1 and clears on decoded 0.
    - After 6 ones, the next bit is a stuff bit. A decoded 0 is discarded and clears the counter. A decoded 1 gives an rx_err pulse → ABORT.
    - Non-stuff bits shift into an LSB-first shift register, and the bit counter increments.
    - At the 8th bit, rx_data is loaded and rx_valid pulses the cycle after that bit_strobe; the bit counter wraps to 0.
    - SE0 → EOP. SE1 → rx_err, ABORT.
  - EOP:
    - Wait for J at bit_strobe, then pulse rx_eop; rx_active=0 the same cycle; → IDLE.
    - Residue bit count 0 or 1 (dribble) is silently discarded.
    - Residue ≥2 also pulses rx_err together with rx_eop.
    - More than 3 bit times without J → ABORT.
  - ABORT: rx_active stays 1 until J is seen following SE0, then rx_active=0 → IDLE. No rx_eop, no further rx_valid.
- Simultaneous events:
  - SE0 arriving at a stuff-bit position is treated as EOP, not a stuff error.
  - rx_valid and rx_eop never coincide: a byte completed on the bit before SE0 is strobed first.
- Reset mid-packet: immediate reset values; no partial byte is ever emitted.
- Latency: SYNC's final K sample → rx_active in 1 cycle. 8th data bit_strobe → rx_valid in 1 cycle.

Decomposition:
- Shared package usbdev_pkg:
  - line_state encodings (LS_SE0, LS_J, LS_K, LS_SE1)
  - rx FSM state enum
  - STUFF_LIMIT=6
  - DRIBBLE_MAX=1
- One sub-module usb_rx_sync_dpll: SYNC_STAGES synchronizer, line_state decode, phase counter, bit_strobe output.

Test Plan:
- Release rst_n with the line idle at J → line_state=01, rx_active=0, no strobes for 100 cycles.
- SYNC + byte 0xA5 + SE0 for 2 bits + J, 4 clk/bit → rx_active rises 1 cycle after the final SYNC K; exactly one rx_valid with rx_data=0xA5; one rx_eop; rx_err never set.
- Bytes 0xFF, 0x01 with the stuffed 0 inserted after six 1s → two rx_valid pulses, rx_data=0xFF then 0x01, rx_err=0.
- Seven consecutive decoded 1s in DATA → rx_err pulse at the 7th bit, no rx_valid or rx_eop afterwards; rx_active falls after SE0 then J.
- Bit periods alternating 3/5 clocks, byte 0x3C → rx_data=0x3C received correctly, no rx_err.
- Assert rst_n low after 4 bits of byte 0x5A → outputs reach reset values without waiting for clk. A following clean 0x5A packet then yields rx_data=0x5A and one rx_eop.

Source files
------------

// File: rtl/usbdev_pkg.sv
// Shared definitions for the poc_usbdev receive path: line-state codes,
// the receive FSM states and the bit-stuffing limits.
package usbdev_pkg;

   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_J   = 2'b01;
   localparam logic [1:0] LS_K   = 2'b10;
   localparam logic [1:0] LS_SE1 = 2'b11;

   localparam int STUFF_LIMIT = 6;
   localparam int DRIBBLE_MAX = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP,
      ST_ABORT
   } rx_state_t;

   function automatic logic is_jk(input logic [1:0] ls);
      return (ls == LS_J) || (ls == LS_K);
   endfunction

endpackage

// File: rtl/usb_rx_sync_dpll.sv
// Pad synchronizer plus a simple DPLL: the phase counter re-aligns on every
// J/K edge and fires bit_strobe near the middle of each bit cell.
module usb_rx_sync_dpll
   import usbdev_pkg::*;
#(
   parameter int OVERSAMPLE  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dp_in,
   input  logic       dm_in,
   output logic [1:0] line_state,
   output logic       bit_strobe
);

   localparam int PW = $clog2(OVERSAMPLE);

   logic [SYNC_STAGES-1:0] dp_sync_reg;
   logic [SYNC_STAGES-1:0] dm_sync_reg;
   logic [1:0]             prev_ls_reg;
   logic [PW-1:0]          phase_reg;
   logic [PW-1:0]          phase_eff;

   assign line_state = {dm_sync_reg[SYNC_STAGES-1], dp_sync_reg[SYNC_STAGES-1]};

   // A J/K edge forces phase zero in the same cycle it is seen.
   always_comb begin
      phase_eff = phase_reg;
      if (is_jk(line_state) && (line_state != prev_ls_reg))
         phase_eff = '0;
   end

   assign bit_strobe = (phase_eff == PW'(OVERSAMPLE/2 - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_sync_reg <= '1;
         dm_sync_reg <= '0;
         prev_ls_reg <= LS_J;
         phase_reg   <= '0;
      end else begin
         dp_sync_reg <= {dp_sync_reg[SYNC_STAGES-2:0], dp_in};
         dm_sync_reg <= {dm_sync_reg[SYNC_STAGES-2:0], dm_in};
         prev_ls_reg <= line_state;
         phase_reg   <= (phase_eff == PW'(OVERSAMPLE - 1)) ? '0 : phase_eff + 1'b1;
      end
   end

endmodule

// File: rtl/usb_fs_rx_deserializer.sv
// Full-speed USB receive front-end: SYNC detection, NRZI decode, de-stuffing
// and LSB-first byte assembly with byte/EOP/error strobes.
module usb_fs_rx_deserializer
   import usbdev_pkg::*;
#(
   parameter int OVERSAMPLE   = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int SYNC_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       dp_in,
   input  logic       dm_in,
   output logic [1:0] line_state,
   output logic       rx_active,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_eop,
   output logic       rx_err
);

   localparam int TW = $clog2(SYNC_TIMEOUT + 1);

   logic bit_strobe;

   usb_rx_sync_dpll #(
      .OVERSAMPLE  (OVERSAMPLE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_dpll (
      .clk        (clk),
      .rst_n      (rst_n),
      .dp_in      (dp_in),
      .dm_in      (dm_in),
      .line_state (line_state),
      .bit_strobe (bit_strobe)
   );

   rx_state_t     state_reg, state_next;
   logic          rx_active_reg, rx_active_next;
   logic [7:0]    rx_data_reg, rx_data_next;
   logic          rx_valid_reg, rx_valid_next;
   logic          rx_eop_reg, rx_eop_next;
   logic          rx_err_reg, rx_err_next;
   logic [7:0]    shift_reg, shift_next;
   logic [2:0]    bit_cnt_reg, bit_cnt_next;
   logic [2:0]    ones_cnt_reg, ones_cnt_next;
   logic [2:0]    alt_cnt_reg, alt_cnt_next;
   logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic [1:0]    eop_cnt_reg, eop_cnt_next;
   logic          se0_seen_reg, se0_seen_next;
   logic [1:0]    prev_level_reg, prev_level_next;
   logic          decoded;

   assign decoded = (line_state == prev_level_reg);

   always_comb begin
      state_next      = state_reg;
      rx_active_next  = rx_active_reg;
      rx_data_next    = rx_data_reg;
      rx_valid_next   = 1'b0;
      rx_eop_next     = 1'b0;
      rx_err_next     = 1'b0;
      shift_next      = shift_reg;
      bit_cnt_next    = bit_cnt_reg;
      ones_cnt_next   = ones_cnt_reg;
      alt_cnt_next    = alt_cnt_reg;
      tmo_cnt_next    = tmo_cnt_reg;
      eop_cnt_next    = eop_cnt_reg;
      se0_seen_next   = se0_seen_reg;
      prev_level_next = prev_level_reg;

      if (bit_strobe && is_jk(line_state))
         prev_level_next = line_state;

      case (state_reg)
         ST_IDLE: begin
            rx_active_next = 1'b0;
            if (bit_strobe && (line_state == LS_K)) begin
               state_next   = ST_SYNC;
               alt_cnt_next = '0;
               tmo_cnt_next = '0;
            end
         end
         ST_SYNC: if (bit_strobe) begin
            if (!is_jk(line_state)) begin
               state_next = ST_IDLE;
            end else if (decoded && (line_state == LS_K) && (alt_cnt_reg >= 3'd3)) begin
               state_next     = ST_DATA;
               rx_active_next = 1'b1;
               bit_cnt_next   = '0;
               ones_cnt_next  = '0;
            end else begin
               // A repeated level that is not the closing KK restarts the count.
               if (decoded)
                  alt_cnt_next = '0;
               else if (alt_cnt_reg != 3'd7)
                  alt_cnt_next = alt_cnt_reg + 3'd1;
               if (tmo_cnt_reg == TW'(SYNC_TIMEOUT - 1))
                  state_next = ST_IDLE;
               else
                  tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
         end
         ST_DATA: if (bit_strobe) begin
            if (line_state == LS_SE0) begin
               state_next   = ST_EOP;
               eop_cnt_next = 2'd1;
            end else if (line_state == LS_SE1) begin
               rx_err_next   = 1'b1;
               state_next    = ST_ABORT;
               se0_seen_next = 1'b0;
            end else if (ones_cnt_reg == 3'(STUFF_LIMIT)) begin
               if (decoded) begin
                  rx_err_next   = 1'b1;
                  state_next    = ST_ABORT;
                  se0_seen_next = 1'b0;
               end else begin
                  ones_cnt_next = '0;
               end
            end else begin
               ones_cnt_next = decoded ? ones_cnt_reg + 3'd1 : 3'd0;
               shift_next    = {decoded, shift_reg[7:1]};
               bit_cnt_next  = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  rx_data_next  = shift_next;
                  rx_valid_next = 1'b1;
               end
            end
         end
         ST_EOP: if (bit_strobe) begin
            if (line_state == LS_J) begin
               rx_eop_next    = 1'b1;
               rx_err_next    = (bit_cnt_reg > 3'(DRIBBLE_MAX));
               rx_active_next = 1'b0;
               state_next     = ST_IDLE;
            end else if (eop_cnt_reg == 2'd3) begin
               state_next    = ST_ABORT;
               se0_seen_next = (line_state == LS_SE0);
            end else begin
               eop_cnt_next = eop_cnt_reg + 2'd1;
            end
         end
         ST_ABORT: if (bit_strobe) begin
            if (line_state == LS_SE0) begin
               se0_seen_next = 1'b1;
            end else if ((line_state == LS_J) && se0_seen_reg) begin
               rx_active_next = 1'b0;
               state_next     = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (!ena) begin
         state_next     = ST_IDLE;
         rx_active_next = 1'b0;
         rx_valid_next  = 1'b0;
         rx_eop_next    = 1'b0;
         rx_err_next    = 1'b0;
         bit_cnt_next   = '0;
         ones_cnt_next  = '0;
         alt_cnt_next   = '0;
         tmo_cnt_next   = '0;
         eop_cnt_next   = '0;
         se0_seen_next  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         rx_active_reg  <= 1'b0;
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         rx_eop_reg     <= 1'b0;
         rx_err_reg     <= 1'b0;
         shift_reg      <= '0;
         bit_cnt_reg    <= '0;
         ones_cnt_reg   <= '0;
         alt_cnt_reg    <= '0;
         tmo_cnt_reg    <= '0;
         eop_cnt_reg    <= '0;
         se0_seen_reg   <= 1'b0;
         prev_level_reg <= LS_J;
      end else begin
         state_reg      <= state_next;
         rx_active_reg  <= rx_active_next;
         rx_data_reg    <= rx_data_next;
         rx_valid_reg   <= rx_valid_next;
         rx_eop_reg     <= rx_eop_next;
         rx_err_reg     <= rx_err_next;
         shift_reg      <= shift_next;
         bit_cnt_reg    <= bit_cnt_next;
         ones_cnt_reg   <= ones_cnt_next;
         alt_cnt_reg    <= alt_cnt_next;
         tmo_cnt_reg    <= tmo_cnt_next;
         eop_cnt_reg    <= eop_cnt_next;
         se0_seen_reg   <= se0_seen_next;
         prev_level_reg <= prev_level_next;
      end
   end

   assign rx_active = rx_active_reg;
   assign rx_data   = rx_data_reg;
   assign rx_valid  = rx_valid_reg;
   assign rx_eop    = rx_eop_reg;
   assign rx_err    = rx_err_reg;

endmodule

// File: tb/tb_usb_fs_rx_deserializer.sv
// Bench for usb_fs_rx_deserializer: an NRZI/bit-stuffing line driver feeds
// packets from a table; a scoreboard checks every byte/EOP/error strobe.
module tb_usb_fs_rx_deserializer;
   import usbdev_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b0;
   logic       dp_in = 1'b1;
   logic       dm_in = 1'b0;
   logic [1:0] line_state;
   logic       rx_active;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_eop;
   logic       rx_err;

   always #5 clk = ~clk;

   usb_fs_rx_deserializer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .dp_in      (dp_in),
      .dm_in      (dm_in),
      .line_state (line_state),
      .rx_active  (rx_active),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_eop     (rx_eop),
      .rx_err     (rx_err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int strobe_cnt = 0;

   typedef enum int {EV_BYTE = 1, EV_EOP = 2, EV_ERR = 3} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
      logic       err;
   } ev_t;
   ev_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every strobe pops the oldest expected event.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n && (rx_valid || rx_eop || rx_err)) begin
         strobe_cnt++;
         if (rx_valid && rx_eop)
            check("valid_eop_overlap", 32'd1, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {29'd0, rx_valid, rx_eop, rx_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            if (rx_valid) begin
               check("kind_byte", 32'(e.kind), 32'(EV_BYTE));
               check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
               $display("rx byte %02h (expected %02h)", rx_data, e.data);
            end else if (rx_eop) begin
               check("kind_eop", 32'(e.kind), 32'(EV_EOP));
               check("eop_err", {31'd0, rx_err}, {31'd0, e.err});
               $display("rx eop err=%0b (expected %0b)", rx_err, e.err);
            end else begin
               check("kind_err", 32'(e.kind), 32'(EV_ERR));
               $display("rx stuff/line error");
            end
         end
      end
   end

   // Line driver state: current NRZI level and ones run for stuffing.
   logic cur_k = 1'b0;
   int   ones = 0;
   logic alt_mode = 1'b0;
   logic alt_ph = 1'b0;

   function automatic int next_period();
      if (!alt_mode) return 4;
      alt_ph = ~alt_ph;
      return alt_ph ? 3 : 5;
   endfunction

   task automatic drive(input logic [1:0] ls, input int n);
      {dm_in, dp_in} = ls;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tx_bit(input logic b, input int n);
      if (!b) cur_k = ~cur_k;
      drive(cur_k ? LS_K : LS_J, n);
   endtask

   task automatic tx_dbit(input logic b);
      tx_bit(b, next_period());
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
         tx_bit(1'b0, next_period());
         ones = 0;
      end
   endtask

   task automatic tx_sync(input logic chk);
      cur_k  = 1'b0;
      ones   = 0;
      alt_ph = 1'b0;
      for (int i = 0; i < 7; i++) tx_bit(1'b0, 4);
      {dm_in, dp_in} = LS_K;
      if (chk) begin
         repeat (3) @(posedge clk);
         @(negedge clk);
         check("active_before_sync_end", {31'd0, rx_active}, 32'd0);
         @(posedge clk);
         #1;
         check("active_after_sync_end", {31'd0, rx_active}, 32'd1);
      end else begin
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   task automatic tx_byte(input logic [7:0] d, input logic push);
      if (push) exp_q.push_back('{EV_BYTE, d, 1'b0});
      for (int i = 0; i < 8; i++) tx_dbit(d[i]);
   endtask

   task automatic tx_eop(input logic push, input logic err);
      if (push) exp_q.push_back('{EV_EOP, 8'h00, err});
      drive(LS_SE0, 8);
      drive(LS_J, 40);
      cur_k = 1'b0;
   endtask

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      int         nbytes;
      int         resid;
      logic       alt;
      logic       eop_err;
   } vec_t;
   vec_t vecs[5];

   initial begin
      #1 rst_n = 1'b0;
      vecs[0] = '{8'hA5, 8'h00, 1, 0, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 2, 0, 1'b0, 1'b0};
      vecs[2] = '{8'h3C, 8'h00, 1, 0, 1'b1, 1'b0};
      vecs[3] = '{8'h12, 8'h00, 1, 2, 1'b0, 1'b1};
      vecs[4] = '{8'h34, 8'h00, 1, 1, 1'b0, 1'b0};

      repeat (5) @(posedge clk);
      #1;
      check("reset_line_state", {30'd0, line_state}, {30'd0, LS_J});
      check("reset_rx_active", {31'd0, rx_active}, 32'd0);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      rst_n = 1'b1;
      ena   = 1'b1;
      drive(LS_J, 100);
      check("idle_strobes", strobe_cnt, 32'd0);
      check("idle_rx_active", {31'd0, rx_active}, 32'd0);
      check("idle_line_state", {30'd0, line_state}, {30'd0, LS_J});

      for (int v = 0; v < 5; v++) begin
         tx_sync(v == 0);
         alt_mode = vecs[v].alt;
         tx_byte(vecs[v].b0, 1'b1);
         if (vecs[v].nbytes > 1) tx_byte(vecs[v].b1, 1'b1);
         for (int r = 0; r < vecs[v].resid; r++) tx_dbit(1'b0);
         alt_mode = 1'b0;
         tx_eop(1'b1, vecs[v].eop_err);
         check("pkt_drained", exp_q.size(), 32'd0);
         check("pkt_active_low", {31'd0, rx_active}, 32'd0);
      end

      // Seven decoded ones in a row: stuff violation, then abort until SE0+J.
      tx_sync(1'b0);
      exp_q.push_back('{EV_ERR, 8'h00, 1'b0});
      for (int i = 0; i < 7; i++) tx_bit(1'b1, 4);
      drive(LS_J, 8);
      check("abort_active_held", {31'd0, rx_active}, 32'd1);
      drive(LS_SE0, 8);
      check("abort_active_se0", {31'd0, rx_active}, 32'd1);
      drive(LS_J, 40);
      check("abort_active_cleared", {31'd0, rx_active}, 32'd0);
      check("abort_drained", exp_q.size(), 32'd0);

      // Asynchronous reset part-way through a byte.
      tx_sync(1'b0);
      for (int i = 0; i < 4; i++) tx_dbit(1'b0 ^ ((8'h5A >> i) & 1));
      #3 rst_n = 1'b0;
      #1;
      check("async_rx_active", {31'd0, rx_active}, 32'd0);
      check("async_rx_data", {24'd0, rx_data}, 32'd0);
      check("async_line_state", {30'd0, line_state}, {30'd0, LS_J});
      check("async_strobes", {29'd0, rx_valid, rx_eop, rx_err}, 32'd0);
      drive(LS_J, 4);
      rst_n = 1'b1;
      cur_k = 1'b0;
      drive(LS_J, 20);
      tx_sync(1'b0);
      tx_byte(8'h5A, 1'b1);
      tx_eop(1'b1, 1'b0);
      check("post_reset_rx_data", {24'd0, rx_data}, 32'h5A);
      check("post_reset_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
